sc_stream_counter: RTL and testbench
====================================

Name: sc_stream_counter

Overview:
- Stochastic-to-binary converter directly downstream of the weighted stochastic mux.
- Counts the 1s in a fixed-length unipolar bitstream window of L = 2**WIDTH valid samples.
- Presents the count as a binary result through a valid/ready handshake to the next stage (host or accumulator).
- Window start is software/sequencer controlled; a synchronous abort discards a partial window.

Parameters:
- WIDTH, 8, log2 of window length; L = 2**WIDTH samples per conversion (WIDTH >= 1)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new conversion window; honoured only in IDLE
- abort  input  1  synchronous cancel of the current window or held result
- din  input  1  stochastic bit from the mux output
- din_valid  input  1  din is a real sample this cycle
- busy  output  1  high in ACCUM
- result  output  WIDTH+1  count of 1s in the last completed window, range 0..L
- result_valid  output  1  result is available (HOLD state)
- result_ready  input  1  consumer accepts result

Behaviour:
- Reset: rst_n low asynchronously forces state to IDLE. Reset values: busy=0, result=0, result_valid=0, internal ones-counter=0, sample-counter=0. The reset takes effect immediately, including mid-window.
- All outputs are registered.
- FSM states:
  - IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 and abort=0 -> clear ones-counter and sample-counter, go to ACCUM. busy=1 from the next cycle.
  - din and din_valid are ignored.
- ACCUM:
  - Each cycle with din_valid=1: sample-counter += 1 and ones-counter += din.
  - Cycles with din_valid=0 change nothing and do not advance the window.
  - The window closes on the cycle that accepts the L-th valid sample (sample-counter = L-1 with din_valid=1). On that edge:
    - result <= ones-counter + din
    - result_valid <= 1, busy <= 0
    - state -> HOLD
  - Latency: result_valid is visible the cycle after the L-th valid sample.
- HOLD:
  - result and result_valid stay stable until the handshake. On result_valid & result_ready: result_valid <= 0 and state -> IDLE.
  - result keeps its last value after the handshake, until the next window completes.
- start:
  - Ignored in ACCUM and HOLD. It is not queued.
  - A start in the same cycle as the HOLD handshake is also ignored; a new start is needed in IDLE.
- abort:
  - Highest priority in every state.
  - In ACCUM or HOLD: next state IDLE, busy=0, result_valid=0, counters cleared. result keeps its previous value; it is not updated by a partial window.
  - abort with start in IDLE: stay in IDLE.
  - abort on the closing sample cycle: the window is discarded and result_valid stays 0.
- Width and arithmetic:
  - ones-counter and result are WIDTH+1 bits, so an all-ones window gives exactly L with no wrap.
  - sample-counter is WIDTH bits and is only compared, never wraps within a window.
- Unsigned unipolar encoding. Probability estimate = result / L. No bipolar correction in this block.

Test Plan:
- WIDTH=4: start, then 16 cycles of din=1, din_valid=1 -> busy high for 16 cycles; result_valid rises the cycle after the 16th sample with result=16 (5'b10000); result_ready=1 -> IDLE next cycle.
- WIDTH=4: din=0 for 16 valid samples -> result=0, result_valid=1; then din=1010... pattern over 16 valid samples with din_valid low on every 3rd cycle -> result=8; completion only after the 16th valid sample (about 24 cycles).
- Hold check: complete a window with result=5 and hold result_ready=0 for 6 cycles while pulsing start and toggling din -> result stays 5, result_valid stays 1, state stays HOLD; ready=1 -> result_valid=0 next cycle, result still 5.
- Abort: start, 7 valid samples of 1, abort=1 -> IDLE next cycle, busy=0, no result_valid, result unchanged. New window of 16 ones -> result=16, with no carry-over of the 7.
- Simultaneous events: start+abort in IDLE -> stays IDLE. abort on the 16th valid sample -> no result_valid. start asserted on the HOLD handshake cycle -> ignored, IDLE.
- Reset: rst_n low mid-ACCUM (asynchronously, between clock edges) -> busy, result, result_valid are 0 immediately. After release, the next window counts correctly (e.g. 16 ones -> 16).

Source files
------------

// File: rtl/sc_stream_counter.sv
`default_nettype none
// ============================================================================
// Module   : sc_stream_counter
// Purpose  : Counts the 1s in a 2**WIDTH-sample unipolar stochastic window and
//            hands the binary count downstream over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module sc_stream_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             din,
   input  logic             din_valid,
   output logic             busy,
   output logic [WIDTH:0]   result,
   output logic             result_valid,
   input  logic             result_ready
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_accum = 2'd1;
   localparam logic [1:0] c_st_hold  = 2'd2;

   localparam logic [WIDTH-1:0] c_last_sample = {WIDTH{1'b1}};
   localparam logic [WIDTH:0]   c_ones_zero   = '0;
   localparam logic [WIDTH-1:0] c_samp_zero   = '0;

   logic [1:0]       state_q, state_d;
   logic [WIDTH:0]   ones_q, ones_d;
   logic [WIDTH-1:0] samp_q, samp_d;
   logic [WIDTH:0]   result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             busy_q, busy_d;

   logic [WIDTH:0]   w_din_ext;
   logic [WIDTH:0]   w_ones_inc;
   logic             w_closing;

   assign w_din_ext  = {{WIDTH{1'b0}}, din};
   assign w_ones_inc = ones_q + w_din_ext;
   assign w_closing  = din_valid && (samp_q == c_last_sample);

   always_comb begin
      state_d        = state_q;
      ones_d         = ones_q;
      samp_d         = samp_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      busy_d         = busy_q;

      case (state_q)
         c_st_idle: begin
            if (!abort && start) begin
               ones_d  = c_ones_zero;
               samp_d  = c_samp_zero;
               busy_d  = 1'b1;
               state_d = c_st_accum;
            end
         end

         c_st_accum: begin
            if (abort) begin
               // Partial window is discarded; result keeps the last full count.
               ones_d  = c_ones_zero;
               samp_d  = c_samp_zero;
               busy_d  = 1'b0;
               state_d = c_st_idle;
            end else if (w_closing) begin
               result_d       = w_ones_inc;
               result_valid_d = 1'b1;
               busy_d         = 1'b0;
               ones_d         = c_ones_zero;
               samp_d         = c_samp_zero;
               state_d        = c_st_hold;
            end else if (din_valid) begin
               ones_d = w_ones_inc;
               samp_d = samp_q + 1'b1;
            end
         end

         c_st_hold: begin
            if (abort || result_ready) begin
               result_valid_d = 1'b0;
               ones_d         = c_ones_zero;
               samp_d         = c_samp_zero;
               state_d        = c_st_idle;
            end
         end

         default: begin
            ones_d         = c_ones_zero;
            samp_d         = c_samp_zero;
            result_valid_d = 1'b0;
            busy_d         = 1'b0;
            state_d        = c_st_idle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= c_st_idle;
         ones_q         <= '0;
         samp_q         <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         ones_q         <= ones_d;
         samp_q         <= samp_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         busy_q         <= busy_d;
      end
   end

   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_stream_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_stream_counter
// Purpose  : Directed self-checking bench for sc_stream_counter at WIDTH=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_sc_stream_counter;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic             din;
   logic             din_valid;
   logic             busy;
   logic [WIDTH:0]   result;
   logic             result_valid;
   logic             result_ready;

   int checks;
   int errors;

   sc_stream_counter #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .din          (din),
      .din_valid    (din_valid),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Feed n valid samples of value d.
   task automatic feed(input int n, input logic d);
      din       = d;
      din_valid = 1'b1;
      repeat (n) tick();
      din_valid = 1'b0;
      din       = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int valid_cnt;
      int cycles;
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      din          = 1'b0;
      din_valid    = 1'b0;
      result_ready = 1'b0;

      #12;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_result", {27'd0, result}, 32'd0);
      chk("reset_rv", {31'd0, result_valid}, 32'd0);
      #5 rst_n = 1'b1;
      tick();

      // All-ones window: busy for 16 cycles, result 16 the cycle after.
      do_start();
      chk("ones_busy_rise", {31'd0, busy}, 32'd1);
      din = 1'b1;
      din_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("ones_busy_during", {31'd0, busy}, 32'd1);
         tick();
         if (i < 15) chk("ones_rv_early", {31'd0, result_valid}, 32'd0);
      end
      din_valid = 1'b0;
      din = 1'b0;
      chk("ones_rv", {31'd0, result_valid}, 32'd1);
      chk("ones_result", {27'd0, result}, 32'd16);
      chk("ones_busy_fall", {31'd0, busy}, 32'd0);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk("ones_handshake_rv", {31'd0, result_valid}, 32'd0);

      // All-zeros window.
      do_start();
      feed(16, 1'b0);
      chk("zeros_rv", {31'd0, result_valid}, 32'd1);
      chk("zeros_result", {27'd0, result}, 32'd0);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;

      // 1010 pattern with every third cycle invalid: 16 valid samples take 23 cycles.
      do_start();
      valid_cnt = 0;
      cycles = 0;
      while (valid_cnt < 16 && cycles < 100) begin
         din_valid = (cycles % 3) != 2;
         din       = (valid_cnt % 2) == 0;
         if (din_valid) valid_cnt++;
         tick();
         cycles++;
         if (valid_cnt < 16) chk("pat_rv_early", {31'd0, result_valid}, 32'd0);
      end
      din_valid = 1'b0;
      din = 1'b0;
      chk("pat_cycles", cycles, 32'd23);
      chk("pat_rv", {31'd0, result_valid}, 32'd1);
      chk("pat_result", {27'd0, result}, 32'd8);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;

      // Hold: result 5 stays put while start pulses and din toggles.
      do_start();
      feed(5, 1'b1);
      feed(11, 1'b0);
      for (int i = 0; i < 6; i++) begin
         start     = i[0];
         din       = ~i[0];
         din_valid = 1'b1;
         tick();
         chk("hold_result", {27'd0, result}, 32'd5);
         chk("hold_rv", {31'd0, result_valid}, 32'd1);
         chk("hold_busy", {31'd0, busy}, 32'd0);
      end
      start = 1'b0;
      din = 1'b0;
      din_valid = 1'b0;
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk("hold_release_rv", {31'd0, result_valid}, 32'd0);
      chk("hold_release_result", {27'd0, result}, 32'd5);

      // Abort after 7 ones, then a clean window must not carry them over.
      do_start();
      feed(7, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_rv", {31'd0, result_valid}, 32'd0);
      chk("abort_result", {27'd0, result}, 32'd5);
      tick();
      chk("abort_stays_idle", {31'd0, busy}, 32'd0);
      do_start();
      feed(16, 1'b1);
      chk("post_abort_rv", {31'd0, result_valid}, 32'd1);
      chk("post_abort_result", {27'd0, result}, 32'd16);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;

      // start together with abort in IDLE stays IDLE.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("start_abort_busy2", {31'd0, busy}, 32'd0);

      // Abort on the closing sample discards the window.
      do_start();
      feed(15, 1'b0);
      din = 1'b0;
      din_valid = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      din_valid = 1'b0;
      chk("abort_last_rv", {31'd0, result_valid}, 32'd0);
      chk("abort_last_busy", {31'd0, busy}, 32'd0);
      chk("abort_last_result", {27'd0, result}, 32'd16);

      // start on the handshake cycle is ignored.
      do_start();
      feed(16, 1'b0);
      chk("hs_pre_rv", {31'd0, result_valid}, 32'd1);
      chk("hs_pre_result", {27'd0, result}, 32'd0);
      start = 1'b1;
      result_ready = 1'b1;
      tick();
      start = 1'b0;
      result_ready = 1'b0;
      chk("hs_start_rv", {31'd0, result_valid}, 32'd0);
      chk("hs_start_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("hs_start_not_queued", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-window.
      do_start();
      feed(5, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_result", {27'd0, result}, 32'd0);
      chk("async_rst_rv", {31'd0, result_valid}, 32'd0);
      tick();
      #2 rst_n = 1'b1;
      tick();
      do_start();
      feed(16, 1'b1);
      chk("post_rst_rv", {31'd0, result_valid}, 32'd1);
      chk("post_rst_result", {27'd0, result}, 32'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
